// File: rtl/prio_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prio_arbiter_pkg
// Purpose  : Shared constants and helpers for the priority arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package prio_arbiter_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/prio_arbiter_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prio_pick
// Purpose  : Finds the highest set bit of c at or below start, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module prio_pick
    import prio_arbiter_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] c,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int pos;
        logic [W-1:0] pos_idx;
        pos     = 0;
        pos_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            pos_idx = W'(pos);
            if (!found && c[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prio_arbiter
// Purpose  : Registered N-way fixed / round-robin arbiter with hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 0,
    localparam int W        = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid,
    output logic         preempt
);

    localparam int            HW        = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [W-1:0]  TOP_IDX   = W'(N - 1);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          preempt_q, preempt_d;

    logic [N-1:0]  cur_mask;
    logic [W-1:0]  ptr_after;
    logic          is_release;
    logic          is_timeout;
    logic          took_preempt;
    logic [N-1:0]  pick_c;
    logic [W-1:0]  pick_start;
    logic [W-1:0]  pick_idx;
    logic          pick_found;

    // Candidate and scan start for the single shared picker.
    always_comb begin
        cur_mask   = ONE << cur_q;
        ptr_after  = (cur_q == '0) ? TOP_IDX : cur_q - W'(1);
        is_release = (state_q == ST_GRANT) && !req[cur_q];
        is_timeout = (state_q == ST_GRANT) && !is_release && (MAX_HOLD != 0) &&
                     (hold_q == HOLD_LAST) && (|(req & ~cur_mask));
        pick_c     = is_timeout ? (req & ~cur_mask) : req;
        if (mode == MODE_FIXED) begin
            pick_start = TOP_IDX;
        end else if (state_q == ST_IDLE) begin
            pick_start = ptr_q;
        end else begin
            pick_start = ptr_after;
        end
    end

    prio_pick #(
        .N (N)
    ) u_pick (
        .c     (pick_c),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            ptr_q     <= TOP_IDX;
            hold_q    <= '0;
            gnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            preempt_q <= preempt_d;
        end
    end

    // Release takes precedence over timeout, so preempt only follows a true timeout.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        took_preempt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    cur_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            default: begin
                if (is_release || is_timeout) begin
                    ptr_d        = ptr_after;
                    hold_d       = '0;
                    took_preempt = is_timeout;
                    if (pick_found) begin
                        cur_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        cur_d   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
    end

    always_comb begin
        gnt_d     = (state_d == ST_GRANT) ? (ONE << cur_d) : '0;
        preempt_d = took_preempt;
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = cur_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prio_arbiter
// Purpose  : Self-checking bench for prio_arbiter (N=4, MAX_HOLD 0 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mode;

    logic [3:0] gnt0, gnt4;
    logic [1:0] idx0, idx4;
    logic       val0, val4;
    logic       pre0, pre4;

    int checks = 0;
    int errors = 0;

    prio_arbiter #(.N(4), .MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .preempt(pre0)
    );

    prio_arbiter #(.N(4), .MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .preempt(pre4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Reference model: owner (-1 = none), cycles owned, round-robin pointer.
    int owner [2];
    int age   [2];
    int rrp   [2];
    bit mpre  [2];
    int limit [2] = '{0, 4};

    function automatic int winner(input logic [3:0] c, input logic rr, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = rr ? ((p - k + 4) % 4) : (3 - k);
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int j = 0; j < 2; j++) begin
            logic [3:0] others;
            mpre[j] = 1'b0;
            if (rst) begin
                owner[j] = -1;
                age[j]   = 0;
                rrp[j]   = 3;
            end else if (owner[j] < 0) begin
                owner[j] = winner(req, mode, rrp[j]);
                age[j]   = 1;
            end else begin
                others = req & ~(4'(1) << owner[j]);
                if (!req[owner[j]]) begin
                    rrp[j]   = (owner[j] + 3) % 4;
                    owner[j] = winner(req, mode, rrp[j]);
                    age[j]   = 1;
                end else if (limit[j] > 0 && age[j] >= limit[j] && others != 4'b0) begin
                    rrp[j]   = (owner[j] + 3) % 4;
                    owner[j] = winner(others, mode, rrp[j]);
                    age[j]   = 1;
                    mpre[j]  = 1'b1;
                end else begin
                    age[j] = age[j] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg0, eg4;
        eg0 = (owner[0] >= 0) ? (4'(1) << owner[0]) : 4'b0;
        eg4 = (owner[1] >= 0) ? (4'(1) << owner[1]) : 4'b0;
        chk("m0_gnt", 32'(gnt0), 32'(eg0));
        chk("m0_idx", 32'(idx0), (owner[0] >= 0) ? 32'(owner[0]) : 32'd0);
        chk("m0_valid", 32'(val0), 32'(|eg0));
        chk("m0_preempt", 32'(pre0), 32'(mpre[0]));
        chk("m4_gnt", 32'(gnt4), 32'(eg4));
        chk("m4_idx", 32'(idx4), (owner[1] >= 0) ? 32'(owner[1]) : 32'd0);
        chk("m4_valid", 32'(val4), 32'(|eg4));
        chk("m4_preempt", 32'(pre4), 32'(mpre[1]));
    endtask

    task automatic tick(input logic r, input logic m, input logic [3:0] q);
        rst  = r;
        mode = m;
        req  = q;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    typedef struct packed {
        logic       r;
        logic       m;
        logic [3:0] q;
        logic [3:0] g;
        logic [1:0] i;
    } vec_t;

    vec_t tbl [19];

    localparam int CONT_IDX [12] = '{3, 3, 3, 3, 0, 0, 0, 0, 3, 3, 3, 3};
    localparam int CONT_PRE [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        logic [3:0] rq;
        logic       rm;
        logic       rr;

        // Expected outputs of the MAX_HOLD=0 instance after each edge.
        tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'b1111, 4'b1000, 2'd3};
        tbl[3]  = '{1'b0, 1'b0, 4'b0110, 4'b0100, 2'd2};
        tbl[4]  = '{1'b0, 1'b0, 4'b0110, 4'b0100, 2'd2};
        tbl[5]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[7]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0};
        tbl[8]  = '{1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3};
        tbl[9]  = '{1'b0, 1'b1, 4'b0111, 4'b0100, 2'd2};
        tbl[10] = '{1'b0, 1'b1, 4'b1011, 4'b0010, 2'd1};
        tbl[11] = '{1'b0, 1'b1, 4'b1101, 4'b0001, 2'd0};
        tbl[12] = '{1'b0, 1'b1, 4'b1110, 4'b1000, 2'd3};
        tbl[13] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2};
        tbl[14] = '{1'b1, 1'b1, 4'b0100, 4'b0000, 2'd0};
        tbl[15] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2};
        tbl[16] = '{1'b0, 1'b0, 4'b0101, 4'b0100, 2'd2};
        tbl[17] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 2'd0};
        tbl[18] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0};

        rst  = 1'b1;
        mode = 1'b0;
        req  = 4'b1111;
        for (int j = 0; j < 2; j++) begin
            owner[j] = -1;
            age[j]   = 0;
            rrp[j]   = 3;
            mpre[j]  = 1'b0;
        end

        for (int v = 0; v < 19; v++) begin
            tick(tbl[v].r, tbl[v].m, tbl[v].q);
            chk($sformatf("tbl%0d_gnt", v), 32'(gnt0), 32'(tbl[v].g));
            chk($sformatf("tbl%0d_idx", v), 32'(idx0), 32'(tbl[v].i));
            chk($sformatf("tbl%0d_valid", v), 32'(val0), 32'(|tbl[v].g));
            chk($sformatf("tbl%0d_preempt", v), 32'(pre0), 32'd0);
        end

        // Contended hold limit: two requesters alternate every 4 cycles.
        tick(1'b1, 1'b1, 4'b0000);
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b1, 4'b1001);
            chk($sformatf("cont%0d_idx", c), 32'(idx4), 32'(CONT_IDX[c]));
            chk($sformatf("cont%0d_gnt", c), 32'(gnt4), 32'(4'(1) << CONT_IDX[c]));
            chk($sformatf("cont%0d_preempt", c), 32'(pre4), 32'(CONT_PRE[c]));
        end

        // Uncontended holder keeps the grant; then release coincides with a due timeout.
        tick(1'b1, 1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b1, 4'b0010);
            chk($sformatf("solo%0d_gnt", c), 32'(gnt4), 32'h2);
            chk($sformatf("solo%0d_preempt", c), 32'(pre4), 32'd0);
        end
        tick(1'b0, 1'b1, 4'b0001);
        chk("relwin_gnt", 32'(gnt4), 32'h1);
        chk("relwin_preempt", 32'(pre4), 32'd0);
        tick(1'b0, 1'b1, 4'b0011);
        chk("relwin_hold_gnt", 32'(gnt4), 32'h1);

        // Randomised traffic against the model.
        rq = 4'b0000;
        rm = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            tick(rr, rm, rq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
